// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush with bubble
// insertion and an optional second (skid) entry that breaks the out_ready->in_ready path.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned SKID   = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   localparam bit HasSkid = (SKID != 0);

   logic              head_valid_q, head_valid_d;
   logic [DATA_W-1:0] head_data_q, head_data_d;
   logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              accept;
   logic              rel;

   always_comb begin
      if (HasSkid) begin
         in_ready = !reset && !stall && !skid_valid_q;
      end else begin
         in_ready = !reset && !stall && (!head_valid_q || out_ready);
      end
      // Flush drops the incoming beat and suppresses the release of the head.
      accept = in_valid && in_ready && !flush;
      rel    = head_valid_q && out_ready && !stall && !flush;
   end

   always_comb begin
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      head_ctrl_d  = head_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         head_ctrl_d  = '0;
         skid_ctrl_d  = '0;
      end else if (!stall) begin
         if (skid_valid_q) begin
            // in_ready is low here, so only the skid->head move can occur.
            if (rel) begin
               head_data_d  = skid_data_q;
               head_ctrl_d  = skid_ctrl_q;
               skid_valid_d = 1'b0;
            end
         end else if (accept) begin
            if (!head_valid_q || rel) begin
               head_valid_d = 1'b1;
               head_data_d  = in_data;
               head_ctrl_d  = in_ctrl;
            end else if (HasSkid) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
               skid_ctrl_d  = in_ctrl;
            end
         end else if (rel) begin
            head_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
         head_ctrl_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
      end else begin
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
         head_ctrl_q  <= head_ctrl_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
      end
   end

   always_comb begin
      out_valid = head_valid_q;
      out_data  = head_data_q;
      out_ctrl  = head_valid_q ? head_ctrl_q : '0;
      occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives one SKID=0 and one SKID=1 stage with shared stimulus and checks both against
// a small FIFO model of the stage.
module tb_pipe_stage_reg;

   logic        clock = 1'b0;
   logic        reset, stall, flush, in_valid, out_ready;
   logic [63:0] in_data;
   logic [15:0] in_ctrl;

   logic        rdy  [2];
   logic        ov   [2];
   logic [63:0] od   [2];
   logic [15:0] oc   [2];
   logic [1:0]  occ  [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Model: per instance, an ordered list of held beats plus the last payload left in the head.
   logic [63:0] md    [2][2];
   logic [15:0] mc    [2][2];
   int          cnt   [2];
   logic [63:0] stale [2];
   logic        mrdy  [2];

   always #5 clock = ~clock;

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(0)) u_s0 (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
      .occupancy(occ[0])
   );

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID(1)) u_s1 (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
      .occupancy(occ[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input int k);
      bit rel, acc;
      if (reset) begin
         cnt[k]   = 0;
         stale[k] = '0;
      end else if (flush) begin
         if (cnt[k] > 0) stale[k] = md[k][0];
         cnt[k] = 0;
      end else if (!stall) begin
         rel = (cnt[k] > 0) && out_ready;
         acc = in_valid && mrdy[k];
         if (rel) begin
            stale[k] = md[k][0];
            md[k][0] = md[k][1];
            mc[k][0] = mc[k][1];
            cnt[k]--;
         end
         if (acc) begin
            md[k][cnt[k]] = in_data;
            mc[k][cnt[k]] = in_ctrl;
            cnt[k]++;
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic f, input logic iv,
                       input logic [63:0] d, input logic [15:0] c, input logic ordy);
      reset = r; stall = s; flush = f; in_valid = iv; in_data = d; in_ctrl = c;
      out_ready = ordy;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         if (k == 0) mrdy[k] = !r && !s && (cnt[k] == 0 || ordy);
         else        mrdy[k] = !r && !s && (cnt[k] < 2);
         chk($sformatf("s%0d.in_ready", k), 64'(rdy[k]), 64'(mrdy[k]));
         chk($sformatf("s%0d.out_valid", k), 64'(ov[k]), 64'(cnt[k] > 0));
         chk($sformatf("s%0d.out_data", k), od[k], (cnt[k] > 0) ? md[k][0] : stale[k]);
         chk($sformatf("s%0d.out_ctrl", k), 64'(oc[k]), (cnt[k] > 0) ? 64'(mc[k][0]) : 64'd0);
         chk($sformatf("s%0d.occupancy", k), 64'(occ[k]), 64'(cnt[k]));
      end
      @(posedge clock);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0, ordy);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; stale[k] = '0; mrdy[k] = 1'b0;
      end
      reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // Reset and bubble
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 64'hdead, 16'hbeef, 1'b1);
      idle(1'b0, 2);

      // Streaming
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 64'(8'h10 + i), 16'(i + 1), 1'b1);
      idle(1'b1, 2);

      // Backpressure
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'hAA, 16'h00A1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'hBB, 16'h00B1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'hCC, 16'h00C1, 1'b0);
      idle(1'b0, 1);
      idle(1'b1, 4);

      // Stall with a held head
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h55, 16'h0055, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 64'h66, 16'h0066, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h66, 16'h0066, 1'b1);
      idle(1'b1, 3);

      // Flush with a full stage and an incoming beat
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 16'h0011, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h22, 16'h0022, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 64'h99, 16'h0099, 1'b1);
      idle(1'b1, 3);

      // Flush during stall, then reset while a beat is held
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h33, 16'h0033, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 64'h44, 16'h0044, 1'b1);
      idle(1'b0, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 16'h0077, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 64'h88, 16'h0088, 1'b1);
      idle(1'b1, 2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 10, $urandom_range(99) < 5,
              $urandom_range(99) < 70, {$urandom, $urandom}, 16'($urandom),
              $urandom_range(99) < 60);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the CPU pipeline. Replaces the fixed per-stage registers with one block carrying a data payload and a control payload.
- Adds a valid/ready handshake, stall, flush with bubble insertion, and an optional 2-entry skid buffer.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Hazard logic drives stall and flush.

Parameters:
- DATA_W, 64, width of data payload (operands, PC, immediates).
- CTRL_W, 16, width of control payload (regwrite, memread, etc.). Zeroed on bubble.
- SKID, 0, 0 = single-entry register; 1 = two-entry skid buffer (no combinational out_ready->in_ready path).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- stall  in  1  freeze stage: no accept, no release, contents held.
- flush  in  1  discard all held beats and the incoming beat; stage becomes empty.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  head beat present.
- out_ready  in  1  downstream accepts head this cycle.
- out_data  out  DATA_W  head data payload.
- out_ctrl  out  CTRL_W  head control payload; forced to 0 when out_valid=0.
- occupancy  out  2  number of held beats (0..1 if SKID=0, 0..2 if SKID=1).

Behaviour:
- Reset (reset=1 at posedge): all entries invalid; stored data and ctrl = 0; occupancy = 0; out_valid = 0; out_data = 0; out_ctrl = 0. in_ready = 0 while reset is asserted; in_ready = 1 in the first cycle after deassertion.
- Accept = in_valid & in_ready. Release = out_valid & out_ready & !stall.
- Bubble rule: out_ctrl = head_valid ? head_ctrl : 0, always (combinational mask). out_data is not masked.
- Priority per cycle: reset > flush > stall > normal.
- flush=1: all valid bits and occupancy clear at the next edge. Stored ctrl entries are zeroed; data is retained. The incoming beat is dropped, even if in_ready=1. The head is not counted as released, even if out_ready=1. Flush asserted while stalled still empties the stage.
- stall=1 (flush=0): in_ready = 0; all state holds; out_valid and out_data stay stable and visible.
- SKID=0, normal operation:
  - in_ready = !stall & (!head_valid | out_ready), a combinational path from out_ready.
  - On accept, head <= in payload at the edge (1-cycle latency).
  - Release without accept: head_valid <= 0.
  - Release with accept in the same cycle: head is replaced, giving full throughput.
- SKID=1, normal operation:
  - Entries are head and skid. in_ready = !stall & !skid_valid, registered only; no out_ready dependency.
  - Accept with head empty (or head releasing and skid empty): payload goes to head.
  - Accept with head held and not releasing: payload goes to skid.
  - Release with skid valid: skid moves to head; a beat accepted in the same cycle is impossible because in_ready=0.
  - Order is strictly FIFO. Occupancy 2 forces in_ready=0 next cycle.
  - Full throughput with 1-cycle latency when out_ready stays high.
- Payload stability: out_data and out_ctrl change only at an edge where release, flush, or reset occurs, or where a beat enters an empty head.
- occupancy updates at the edge together with the valid bits. It never exceeds 1+SKID. An accept at full occupancy is impossible because in_ready=0.
- No X propagation: out_ctrl is 0 whenever out_valid=0, including straight after reset and after flush.

Test Plan:
- Reset/bubble: SKID=0. Reset 3 cycles, then idle -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 on the first post-reset cycle.
- Streaming: SKID=1, out_ready=1. Send data 0x10..0x17 with ctrl 0x0001..0x0008 on consecutive cycles -> each appears 1 cycle later, in order, no gaps, occupancy never exceeds 1.
- Backpressure: SKID=1. Send A=0xAA, B=0xBB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xAA held. Raise out_ready -> 0xAA then 0xBB, occupancy 2->1->0.
- Stall: SKID=0, head=0x55, assert stall for 4 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_data=0x55 held, no beat lost or duplicated after release.
- Flush: SKID=1, occupancy=2, assert flush with in_valid=1, in_data=0x99 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and 0x99 never appears.
- Flush during stall plus mid-operation reset: SKID=0. Head valid, stall=1 and flush=1 together -> stage empties. Then reset asserted while a beat is held -> occupancy=0, out_ctrl=0 next cycle.
